// File: rtl/multicycle_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice is reused NSLICE times.
// The carry is held in a register between slices, and the result is published only when the last slice completes.
module multicycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry into slice MSB, carry out, sum} for one ripple slice.
    function automatic logic [DIGIT+1:0] slice_add(
        input logic [DIGIT-1:0] a,
        input logic [DIGIT-1:0] b,
        input logic             cin
    );
        logic [DIGIT:0]   c;
        logic [DIGIT-1:0] s;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        return {c[DIGIT-1], c[DIGIT], s};
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             ready_q;
    logic             done_q;

    logic [DIGIT-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] psum_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             last_s;

    // Slice arithmetic and next values of the shift registers.
    always_comb begin
        {msb_cin_s, slice_cout_s, slice_sum_s} = slice_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
        // New digit enters at the top so the LSB slice ends up in the low bits.
        psum_d = (psum_q >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        last_s = (cnt_q == CW'(NSLICE - 1));
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    psum_q  <= psum_d;
                    carry_q <= slice_cout_s;
                    if (last_s) begin
                        s_q     <= psum_d;
                        c_out_q <= slice_cout_s;
                        ovf_q   <= msb_cin_s ^ slice_cout_s;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign S     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
